// File: rtl/logic_unit_serial32.sv
// Purpose : serial 32-bit bitwise logic unit (AND/OR/XOR/ANDN), SLICE bits per cycle through one shared slice.
// Latency : request accepted at edge t0, out_valid rises after edge t0+N (N = 32/SLICE); N+2 cycles per result when streaming.
// Backpr. : result/out_valid held indefinitely while out_ready=0; no new request accepted until the result is taken.
// Ports   : clk, rst (async, active-high); in_valid/in_ready + op[1:0], a[31:0], b[31:0] request side;
//           out_valid/out_ready + result[31:0] response side (result meaningful only while out_valid=1).
module logic_unit_serial32 #(
  parameter int SLICE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  localparam int N  = 32 / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       opr_a_q, opr_a_d;
  logic [31:0]       opr_b_q, opr_b_d;
  logic [31:0]       result_q, result_d;
  logic [1:0]        op_q, op_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [SLICE-1:0]  s;
  logic [31:0]       res_shift, a_shift, b_shift;

  // The shared slice: only the low SLICE bits of the operand shift registers.
  always_comb begin
    s = '0;
    case (op_q)
      2'b00:   s = opr_a_q[SLICE-1:0] &  opr_b_q[SLICE-1:0];
      2'b01:   s = opr_a_q[SLICE-1:0] |  opr_b_q[SLICE-1:0];
      2'b10:   s = opr_a_q[SLICE-1:0] ^  opr_b_q[SLICE-1:0];
      default: s = opr_a_q[SLICE-1:0] & ~opr_b_q[SLICE-1:0];
    endcase
  end

  // Result fills from the top so after N slices bit i lands at index i.
  // A full-width slice has nothing left to shift in from the old contents.
  if (SLICE == 32) begin : g_full
    assign res_shift = s;
    assign a_shift   = '0;
    assign b_shift   = '0;
  end else begin : g_part
    assign res_shift = {s, result_q[31:SLICE]};
    assign a_shift   = {{SLICE{1'b0}}, opr_a_q[31:SLICE]};
    assign b_shift   = {{SLICE{1'b0}}, opr_b_q[31:SLICE]};
  end

  always_comb begin
    state_d  = state_q;
    opr_a_d  = opr_a_q;
    opr_b_d  = opr_b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opr_a_d = a;
          opr_b_d = b;
          op_d    = op;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        result_d = res_shift;
        opr_a_d  = a_shift;
        opr_b_d  = b_shift;
        // Single-slice configuration keeps the counter pinned at zero.
        if (N > 1) begin
          cnt_d = cnt_q + CW'(1);
        end
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      opr_a_q  <= '0;
      opr_b_q  <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      opr_a_q  <= opr_a_d;
      opr_b_q  <= opr_b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Handshake outputs are pure state decodes; rst masks in_ready so a
  // request presented during reset can never look accepted.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_logic_unit_serial32.sv
`timescale 1ns/1ps
module tb_logic_unit_serial32;

  localparam int SLICE = 4;
  localparam int N     = 32 / SLICE;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] exp;
    int          acc;
  } txn_t;

  txn_t        pend[$];
  int          acc_log[$];
  logic [31:0] last_res = '0;

  logic_unit_serial32 #(.SLICE(SLICE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference: the whole word at once, straight from the opcode table.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return x & ~y;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the transaction-level model.
  always @(negedge clk) begin
    logic ev;
    if (rst) begin
      pend.delete();
      last_res = '0;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result", result, 32'd0);
    end else begin
      ev = (pend.size() > 0) && (cyc >= pend[0].acc + N);
      check("in_ready", 32'(in_ready), 32'(pend.size() == 0));
      check("out_valid", 32'(out_valid), 32'(ev));
      if (out_valid && ev)
        check("result", result, pend[0].exp);
      else if (pend.size() == 0)
        check("idle_result", result, last_res);
      if (in_valid && in_ready) begin
        txn_t t;
        t.exp = model(op, a, b);
        t.acc = cyc + 1;
        pend.push_back(t);
        acc_log.push_back(cyc + 1);
      end
      if (out_valid && out_ready && pend.size() > 0) begin
        last_res = pend[0].exp;
        void'(pend.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and return just after the accepting edge.
  task automatic send(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int k;
    op = o; a = x; b = y; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 200) begin
      tick();
      k++;
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Returns the number of cycles waited for out_valid.
  task automatic wait_out(output int k);
    k = 0;
    while (!out_valid && k < 200) begin
      tick();
      k++;
    end
    if (!out_valid) check("out_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic directed(input string nm, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] e);
    int k;
    out_ready = 1'b1;
    send(o, x, y);
    wait_out(k);
    check({nm, "_latency"}, 32'(k), 32'(N));
    check({nm, "_result"}, result, e);
    tick();
  endtask

  initial begin
    int          k;
    int          hs;
    int          base;
    logic [31:0] held;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("post_reset_in_ready", 32'(in_ready), 32'd1);

    directed("and",  2'b00, 32'hF0F0_1234, 32'hFF00_FF00, 32'hF000_1200);
    directed("xor",  2'b10, 32'hFFFF_FFFF, 32'h1234_5678, 32'hEDCB_A987);
    directed("or",   2'b01, 32'h0000_00FF, 32'h8000_0000, 32'h8000_00FF);
    directed("andn", 2'b11, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0000);

    // Backpressure with a competing request held on the input.
    out_ready = 1'b0;
    send(2'b01, 32'h1234_0000, 32'h0000_5678);
    wait_out(k);
    held = result;
    check("bp_first", held, 32'h1234_5678);
    in_valid = 1'b1; op = 2'b10; a = 32'hAAAA_AAAA; b = 32'h5555_5555;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold", result, held);
    end
    out_ready = 1'b1;
    tick();
    hs = cyc;
    check("bp_ready_after_hs", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_next_accept", 32'(acc_log[$]), 32'(hs + 1));
    wait_out(k);
    check("bp_second", result, 32'hFFFF_FFFF);
    tick();

    // Asynchronous reset in the middle of BUSY.
    send(2'b10, $urandom, $urandom);
    tick(); tick(); tick();
    #3 rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd0);
    tick(); tick();
    rst = 1'b0;
    #1;
    check("arst_release_in_ready", 32'(in_ready), 32'd1);
    directed("after_rst", 2'b00, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'h0000_FFFF);

    // Streaming: in_valid and out_ready held high.
    out_ready = 1'b1;
    base = acc_log.size();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
      k = 0;
      while (!in_ready && k < 200) begin
        tick();
        k++;
      end
      tick();
    end
    in_valid = 1'b0;
    for (int i = 1; i < 4; i++)
      check("stream_spacing", 32'(acc_log[base + i] - acc_log[base + i - 1]), 32'(N + 2));
    wait_out(k);
    tick();

    // Random operands with random consumer stalls.
    for (int t = 0; t < 20; t++) begin
      out_ready = 1'b0;
      send(2'($urandom_range(0, 3)), $urandom, $urandom);
      k = 0;
      while (k < 300) begin
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) break;
        tick();
        k++;
      end
      if (k >= 300) check("rand_timeout", 32'(k), 32'd0);
      tick();
    end
    out_ready = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
